audio_stream_ctrl: RTL and testbench

//  Sequencer for the audio sample store. Walks the store's word index from a programmed start for a

---
 rtl/audio_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_audio_stream_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_ctrl.sv
// Audio sample store sequencer: walks the store read index and streams words out.
// Ports: clk/rst_n, start/abort control, store_index/store_data store port,
//   out_* valid/ready stream, busy/done/words_sent status.
// Build option: AUDIO_STREAM_LOOP_EN makes word_count==0 a continuous loop.
module audio_stream_ctrl #(
  parameter int INPUT_SIZE = 512,
  parameter int NUM_WORDS  = 4096,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IDX_W-1:0]      start_index,
  input  logic [IDX_W:0]        word_count,
  output logic [IDX_W-1:0]      store_index,
  input  logic [INPUT_SIZE-1:0] store_data,
  output logic [INPUT_SIZE-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W:0]        words_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(NUM_WORDS);

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W:0]          r_left;
  logic [IDX_W:0]          r_sent;
  logic [INPUT_SIZE-1:0]   r_data;
  logic                    r_valid;
  logic                    r_last;
  logic [IDX_W:0]          w_count;
  logic                    w_go;
  logic                    w_accept;
  logic                    w_more;
  logic                    w_load;
  logic                    w_loop;
  logic                    w_busy;
  logic                    w_done;

  assign w_go     = start && !abort && (r_state == S_IDLE);
  assign w_accept = r_valid && out_ready;
  assign w_more   = w_loop || (r_left != '0);
  assign w_load   = (r_state == S_RUN) && w_more &&
                    (!r_valid || out_ready);
  assign w_count  = (word_count > MAX_CNT) ? MAX_CNT : word_count;

`ifdef AUDIO_STREAM_LOOP_EN
  logic r_loop;

  // Loop mode is latched at start; zero count means stream forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loop <= 1'b0;
    end else if (w_go) begin
      r_loop <= (word_count == '0);
    end else if (r_state == S_IDLE) begin
      r_loop <= 1'b0;
    end
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The empty-transfer exit (nothing left, nothing pending) only
  // triggers for a zero count: a normal last beat leaves RUN first.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_accept && r_last) w_next = S_DONE;
        else if (!w_more && !r_valid) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Fetch pointer wraps naturally: NUM_WORDS is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_left <= '0;
    end else if (w_go) begin
      r_ptr  <= start_index;
      r_left <= w_count;
    end else if (w_load) begin
      r_ptr <= r_ptr + 1'b1;
      if (!w_loop) r_left <= r_left - 1'b1;
    end
  end

  // Output register: loads when empty or draining, holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (abort) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_data  <= store_data;
      r_valid <= 1'b1;
      r_last  <= !w_loop && (r_left == (IDX_W+1)'(1));
    end else if (w_accept) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // Accepted beats count even on the abort cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sent <= '0;
    end else if (w_go) begin
      r_sent <= '0;
    end else if (w_accept) begin
      if (w_loop || (r_sent != MAX_CNT)) r_sent <= r_sent + 1'b1;
    end
  end

  assign store_index = r_ptr;
  assign out_data    = r_data;
  assign out_valid   = r_valid;
  assign out_last    = r_last;
  assign busy        = w_busy;
  assign done        = w_done;
  assign words_sent  = r_sent;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Bench for audio_stream_ctrl: table-driven transfers, scoreboard on the
// stream, hand sequences for stall, abort, zero count and reset.
module tb_audio_stream_ctrl;

  localparam int NW = 4096;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [11:0]  start_index;
  logic [12:0]  word_count;
  logic [11:0]  store_index;
  logic [511:0] store_data;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [12:0]  words_sent;

  audio_stream_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .start_index (start_index),
    .word_count  (word_count),
    .store_index (store_index),
    .store_data  (store_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .words_sent  (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign store_data = {64{store_index[7:0]}};

  typedef struct {
    logic [511:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    int si;
    int cnt;
    int exp_sent;
  } vec_t;

  beat_t        sb[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  logic         prev_hold = 1'b0;
  logic [511:0] prev_data;
  logic         prev_last;

  function automatic logic [511:0] wexp(input int k);
    logic [7:0] b;
    b = 8'(k % NW);
    return {64{b}};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer(input int si, input int cnt);
    int n;
    beat_t b;
    n = (cnt > NW) ? NW : cnt;
    for (int k = 0; k < n; k++) begin
      b.d = wexp(si + k);
      b.l = (k == n - 1);
      sb.push_back(b);
    end
  endtask

  // Monitor: scoreboard pops on accepted beats, stall stability check.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (prev_hold) begin
        checks++;
        if (!out_valid || out_data != prev_data ||
            out_last != prev_last) begin
          errors++;
          $display("FAIL stall_hold got v=%0b d=%h l=%0b expected d=%h l=%0b",
                   out_valid, out_data[31:0], out_last,
                   prev_data[31:0], prev_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexp_beat got d=%h expected none",
                   out_data[31:0]);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (out_data != e.d || out_last != e.l) begin
            errors++;
            $display("FAIL beat got d=%h l=%0b expected d=%h l=%0b",
                     out_data[31:0], out_last, e.d[31:0], e.l);
          end
        end
      end
    end
    prev_hold = rst_n && out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
  end

  task automatic drive_start(input int si, input int cnt);
    start       = 1'b1;
    start_index = 12'(si);
    word_count  = 13'(cnt);
    step();
    start = 1'b0;
  endtask

  task automatic run_xfer(input int si, input int cnt, input int exp_sent);
    int got;
    push_xfer(si, cnt);
    drive_start(si, cnt);
    got = 0;
    for (int c = 0; c < cnt + 40; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", got, 1);
    chk("words_sent", int'(words_sent), exp_sent);
    chk("sb_empty", sb.size(), 0);
    step();
  endtask

  vec_t tbl[6];
  int   dc;

  initial begin
    tbl[0] = '{si: 0,    cnt: 4,    exp_sent: 4};
    tbl[1] = '{si: 4094, cnt: 4,    exp_sent: 4};
    tbl[2] = '{si: 100,  cnt: 1,    exp_sent: 1};
    tbl[3] = '{si: 4095, cnt: 2,    exp_sent: 2};
    tbl[4] = '{si: 10,   cnt: 5000, exp_sent: 4096};
    tbl[5] = '{si: 7,    cnt: 4096, exp_sent: 4096};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start_index = '0;
    word_count = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sent", int'(words_sent), 0);
    chk("rst_index", int'(store_index), 0);
    chk("rst_data", int'(out_data != '0), 0);
    step();
    rst_n = 1'b1;
    step();

    // Latency and timing of a 4-word transfer.
    push_xfer(0, 4);
    drive_start(0, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_c%0d", c), int'(out_valid),
          int'(c >= 2 && c <= 5));
      chk($sformatf("t1_done_c%0d", c), int'(done), int'(c == 6));
      chk($sformatf("t1_busy_c%0d", c), int'(busy),
          int'(c >= 1 && c <= 5));
    end
    chk("t1_sent", int'(words_sent), 4);
    chk("t1_sb", sb.size(), 0);
    step();

    for (int i = 0; i < 6; i++) begin
      run_xfer(tbl[i].si, tbl[i].cnt, tbl[i].exp_sent);
    end

    // Stall for 3 cycles on the second beat.
    push_xfer(0, 3);
    drive_start(0, 3);
    step();
    step();
    out_ready = 1'b0;
    step();
    step();
    step();
    out_ready = 1'b1;
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        dc = 1;
        break;
      end
    end
    chk("bp_done", dc, 1);
    chk("bp_sent", int'(words_sent), 3);
    chk("bp_sb", sb.size(), 0);
    step();

    // Abort on the second accepted beat, start in the same cycle.
    dc = done_cnt;
    push_xfer(0, 8);
    drive_start(0, 8);
    step();
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("ab_valid", int'(out_valid), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_sent", int'(words_sent), 2);
    sb.delete();
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("ab_idle_busy", int'(busy), 0);
    step();
    step();
    chk("ab_no_done", done_cnt, dc);

`ifndef AUDIO_STREAM_LOOP_EN
    // Zero-length transfer.
    drive_start(5, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("z_done_c%0d", c), int'(done), int'(c == 2));
      chk($sformatf("z_busy_c%0d", c), int'(busy), int'(c == 1));
    end
    chk("z_sent", int'(words_sent), 0);
    step();
`else
    // Continuous loop across the wrap, exits only on abort.
    dc = done_cnt;
    push_xfer(4090, 5010);
    sb[sb.size() - 1].l = 1'b0;
    drive_start(4090, 0);
    begin
      int ok;
      ok = 0;
      for (int c = 0; c < 6000; c++) begin
        @(negedge clk);
        if (sb.size() <= 10) begin
          ok = 1;
          break;
        end
      end
      chk("loop_beats", ok, 1);
    end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("loop_busy", int'(busy), 0);
    chk("loop_valid", int'(out_valid), 0);
    chk("loop_no_done", done_cnt, dc);
    sb.delete();
    step();
`endif

    // Asynchronous reset in the middle of a transfer.
    push_xfer(0, 8);
    drive_start(0, 8);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_last", int'(out_last), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_sent", int'(words_sent), 0);
    chk("ar_index", int'(store_index), 0);
    chk("ar_data", int'(out_data != '0), 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    run_xfer(200, 5, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
